// File: rtl/seq_divide_if.sv
// Handshake/operand bundle for the sequential restoring divider.
// The master drives the request and operands; the slave (divider) returns results and status.
interface seq_divide_if #(
  parameter int N = 4
);
  logic           start;
  logic           sign;
  logic [2*N-1:0] dividend;
  logic [N-1:0]   divisor;
  logic [N-1:0]   quotient;
  logic [N-1:0]   remainder;
  logic           ready;
  logic           done;
  logic           div_zero;
  logic           overflow;

  modport master (
    output start, sign, dividend, divisor,
    input  quotient, remainder, ready, done, div_zero, overflow
  );

  modport slave (
    input  start, sign, dividend, divisor,
    output quotient, remainder, ready, done, div_zero, overflow
  );
endinterface

// File: rtl/seq_divide.sv
// Sequential restoring divider: 2N-bit dividend / N-bit divisor, one quotient bit per clock.
// Define SEQ_DIV_SIGNED_EN to honour the sign input; otherwise the divider is purely unsigned.
module seq_divide #(
  parameter int N = 4
) (
  input logic         clk,
  input logic         rst_n,
  seq_divide_if.slave bus
);
  localparam int CW = $clog2(N + 1);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t         state;
  logic [N:0]     rem;
  logic [N-1:0]   lo_sh;
  logic [N-1:0]   dvs_mag;
  logic [N-1:0]   q;
  logic [N-1:0]   raw_lo;
  logic [CW-1:0]  cnt;

  logic [2*N-1:0] dvd_abs;
  logic [N-1:0]   dvs_abs;
  logic           early_dz;
  logic           early_ov;

  logic [N:0]     sh;
  logic [N:0]     diff;
  logic           ge;
  logic [N:0]     rem_nx;

  logic [N-1:0]   q_out;
  logic [N-1:0]   r_out;
  logic           sig_ovf;

  // rem never exceeds the divisor magnitude, so its top bit only exists as trial headroom
  logic           unused_rem_msb;
  assign unused_rem_msb = rem[N];

`ifdef SEQ_DIV_SIGNED_EN
  logic neg_q;
  logic neg_r;

  // Magnitude of a 2N-bit operand, formed in 2N+1 bits so the most-negative value does not wrap
  function automatic logic [2*N-1:0] mag_wide(input logic [2*N-1:0] v, input logic s);
    logic signed [2*N:0] ext;
    ext = $signed({s & v[2*N-1], v});
    return ext[2*N] ? (2*N)'(-ext) : v;
  endfunction

  function automatic logic [N-1:0] mag_narrow(input logic [N-1:0] v, input logic s);
    logic signed [N:0] ext;
    ext = $signed({s & v[N-1], v});
    return ext[N] ? N'(-ext) : v;
  endfunction

  function automatic logic [N-1:0] neg_cond(input logic [N-1:0] v, input logic n);
    return n ? ('0 - v) : v;
  endfunction

  always_comb begin
    dvd_abs = mag_wide(bus.dividend, bus.sign);
    dvs_abs = mag_narrow(bus.divisor, bus.sign);
    q_out   = neg_cond(q, neg_q);
    r_out   = neg_cond(rem[N-1:0], neg_r);
    // Negative results may reach -2^(N-1); positive ones stop at 2^(N-1)-1
    sig_ovf = q[N-1] & (~neg_q | (|q[N-2:0]));
  end
`else
  logic unused_sign;
  assign unused_sign = bus.sign;

  always_comb begin
    dvd_abs = bus.dividend;
    dvs_abs = bus.divisor;
    q_out   = q;
    r_out   = rem[N-1:0];
    sig_ovf = 1'b0;
  end
`endif

  always_comb begin
    early_dz = (bus.divisor == '0);
    early_ov = ~early_dz && (dvd_abs[2*N-1:N] >= dvs_abs);
    sh       = {rem[N-1:0], lo_sh[N-1]};
    ge       = (sh >= {1'b0, dvs_mag});
    diff     = sh - {1'b0, dvs_mag};
    rem_nx   = ge ? diff : sh;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      bus.ready     <= 1'b1;
      bus.done      <= 1'b0;
      bus.quotient  <= '0;
      bus.remainder <= '0;
      bus.div_zero  <= 1'b0;
      bus.overflow  <= 1'b0;
      rem           <= '0;
      lo_sh         <= '0;
      dvs_mag       <= '0;
      q             <= '0;
      raw_lo        <= '0;
      cnt           <= '0;
`ifdef SEQ_DIV_SIGNED_EN
      neg_q         <= 1'b0;
      neg_r         <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          bus.done <= 1'b0;
          if (bus.start) begin
            state        <= CALC;
            bus.ready    <= 1'b0;
            rem          <= {1'b0, dvd_abs[2*N-1:N]};
            lo_sh        <= dvd_abs[N-1:0];
            dvs_mag      <= dvs_abs;
            q            <= '0;
            raw_lo       <= bus.dividend[N-1:0];
            cnt          <= '0;
            bus.div_zero <= early_dz;
            bus.overflow <= early_ov;
`ifdef SEQ_DIV_SIGNED_EN
            neg_q        <= bus.sign & (bus.dividend[2*N-1] ^ bus.divisor[N-1]);
            neg_r        <= bus.sign & bus.dividend[2*N-1];
`endif
          end
        end
        CALC: begin
          if (bus.div_zero || bus.overflow) begin
            // Early exit: saturated quotient, raw low dividend as remainder
            state         <= DONE;
            bus.done      <= 1'b1;
            bus.quotient  <= '1;
            bus.remainder <= raw_lo;
          end else if (cnt == CW'(N)) begin
            state         <= DONE;
            bus.done      <= 1'b1;
            bus.quotient  <= q_out;
            bus.remainder <= r_out;
            bus.overflow  <= sig_ovf;
          end else begin
            rem   <= rem_nx;
            lo_sh <= {lo_sh[N-2:0], 1'b0};
            q     <= {q[N-2:0], ge};
            cnt   <= cnt + CW'(1);
          end
        end
        DONE: begin
          state     <= IDLE;
          bus.done  <= 1'b0;
          bus.ready <= 1'b1;
        end
        default: begin
          state     <= IDLE;
          bus.done  <= 1'b0;
          bus.ready <= 1'b1;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_seq_divide.sv
// Scoreboard bench for seq_divide: directed corner cases, reset abort, held start and random operands
// checked against an integer-arithmetic reference model.
module tb_seq_divide;
  localparam int N = 4;
`ifdef SEQ_DIV_SIGNED_EN
  localparam bit SIGNED_EN = 1'b1;
`else
  localparam bit SIGNED_EN = 1'b0;
`endif

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   cyc   = 0;
  int   checks = 0;
  int   fails  = 0;

  seq_divide_if #(.N(N)) bus ();
  seq_divide #(.N(N)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [N-1:0] q;
    logic [N-1:0] r;
    logic         dz;
    logic         ov;
    int           lat;
    int           acc;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Reference: plain integer division, truncating toward zero, remainder takes dividend's sign
  function automatic exp_t model(input logic [2*N-1:0] dvd, input logic [N-1:0] dvs,
                                 input logic sgn, input int acc);
    exp_t   e;
    longint a, b, ma, mb, qt, rm;
    bit     s;
    s = SIGNED_EN && sgn;
    a = longint'(dvd);
    b = longint'(dvs);
    if (s && dvd[2*N-1]) a = a - (longint'(1) << (2*N));
    if (s && dvs[N-1])   b = b - (longint'(1) << N);
    ma = (a < 0) ? -a : a;
    mb = (b < 0) ? -b : b;
    e.acc = acc;
    e.dz  = 1'b0;
    e.ov  = 1'b0;
    if (b == 0) begin
      e.dz = 1'b1; e.q = '1; e.r = dvd[N-1:0]; e.lat = 1;
    end else if (ma / mb >= (longint'(1) << N)) begin
      e.ov = 1'b1; e.q = '1; e.r = dvd[N-1:0]; e.lat = 1;
    end else begin
      qt = a / b;
      rm = a % b;
      e.q = qt[N-1:0];
      e.r = rm[N-1:0];
      e.ov = s && ((qt > (longint'(1) << (N-1)) - 1) || (qt < -(longint'(1) << (N-1))));
      e.lat = N + 1;
    end
    return e;
  endfunction

  always @(negedge clk) begin
    if (rst_n && bus.done) begin
      check("ready_at_done", bus.ready, 0);
      if (exp_q.size() == 0) begin
        checks++;
        fails++;
        $display("FAIL unexpected_done: got done=1, expected no pending operation (cycle %0d)", cyc);
      end else begin
        mon_e = exp_q.pop_front();
        check("quotient",  bus.quotient,  mon_e.q);
        check("remainder", bus.remainder, mon_e.r);
        check("div_zero",  bus.div_zero,  mon_e.dz);
        check("overflow",  bus.overflow,  mon_e.ov);
        check("latency",   cyc - mon_e.acc - 1, mon_e.lat);
      end
    end
  end

  // Waits (bounded) for ready, presents one request for a single cycle
  task automatic issue(input logic [2*N-1:0] dvd, input logic [N-1:0] dvs, input logic sgn);
    int waited;
    waited = 0;
    @(negedge clk);
    while (!bus.ready && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    if (!bus.ready) begin
      checks++;
      fails++;
      $display("FAIL ready_timeout: got ready=0 after %0d cycles, expected ready=1", waited);
      return;
    end
    bus.dividend = dvd;
    bus.divisor  = dvs;
    bus.sign     = sgn;
    bus.start    = 1'b1;
    exp_q.push_back(model(dvd, dvs, sgn, cyc));
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  logic [7:0] d_dvd [10] = '{8'h64, 8'h32, 8'h80, 8'hEC, 8'h38, 8'h80, 8'hC8, 8'hC0, 8'hEF, 8'hF1};
  logic [3:0] d_dvs [10] = '{4'h7, 4'h0, 4'h4, 4'h3, 4'h7, 4'hF, 4'h7, 4'h8, 4'hF, 4'h8};
  logic       d_sgn [10] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
  logic [7:0] h_dvd [3]  = '{8'h64, 8'h23, 8'h40};
  logic [3:0] h_dvs [3]  = '{4'h7, 4'h5, 4'h9};

  initial begin
    int accs[$];
    int waited;
    logic [2*N-1:0] rd;
    logic [N-1:0]   rv;

    bus.start = 1'b0; bus.sign = 1'b0; bus.dividend = '0; bus.divisor = '0;
    repeat (2) @(negedge clk);
    check("rst_ready",     bus.ready,     1);
    check("rst_done",      bus.done,      0);
    check("rst_quotient",  bus.quotient,  0);
    check("rst_remainder", bus.remainder, 0);
    check("rst_flags",     {bus.div_zero, bus.overflow}, 0);
    rst_n = 1'b1;

    for (int i = 0; i < 10; i++) issue(d_dvd[i], d_dvs[i], d_sgn[i]);

    // Abort during CALC: asynchronous reset, no done afterwards
    issue(8'h64, 4'h7, 1'b0);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("abort_ready",     bus.ready,     1);
    check("abort_done",      bus.done,      0);
    check("abort_quotient",  bus.quotient,  0);
    check("abort_remainder", bus.remainder, 0);
    check("abort_flags",     {bus.div_zero, bus.overflow}, 0);
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (8) @(negedge clk);
    issue(8'hEC, 4'h3, 1'b1);

    // Start held high: operands change freely while busy and must be ignored
    waited = 0;
    while (!bus.ready && waited < 50) begin @(negedge clk); waited++; end
    for (int i = 0; i < 40 && accs.size() < 3; i++) begin
      @(negedge clk);
      bus.start = 1'b1;
      if (bus.ready) begin
        bus.dividend = h_dvd[accs.size()];
        bus.divisor  = h_dvs[accs.size()];
        bus.sign     = 1'b0;
        exp_q.push_back(model(bus.dividend, bus.divisor, 1'b0, cyc));
        accs.push_back(cyc);
      end else begin
        bus.dividend = 8'($urandom);
        bus.divisor  = 4'($urandom);
        bus.sign     = 1'($urandom);
      end
    end
    @(negedge clk);
    bus.start = 1'b0;
    check("held_accepts", accs.size(), 3);
    for (int i = 1; i < accs.size(); i++) check("accept_spacing", accs[i] - accs[i-1], N + 3);

    for (int i = 0; i < 200; i++) begin
      rd = 8'($urandom) >> $urandom_range(0, 4);
      rv = ($urandom_range(0, 7) == 0) ? 4'h0 : 4'($urandom);
      issue(rd, rv, 1'($urandom));
    end

    waited = 0;
    while (exp_q.size() != 0 && waited < 100) begin @(negedge clk); waited++; end
    check("drain", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end
endmodule
